fir_decimate_buffer: RTL and testbench
======================================

# fir_decimate_buffer

Downstream stage of the 8th-order FIR lowpass. It accepts the filter's 18-bit unsigned output stream and keeps one sample in every `decim_factor`. Each kept sample is rounded and right-shifted back to the 8-bit sample width, then saturated. Results are buffered in a small show-ahead FIFO drained by a valid/ready consumer.

## Interface
One clock; reset is asynchronous and active-low.

Parameters:
- `word_size_in`, 18, width of the FIR output word consumed.
- `word_size_out`, 8, output sample width.
- `decim_factor`, 4, keep ratio; legal range 1..16.
- `shift`, 8, right-shift applied after rounding; legal range 1..`word_size_in`-1.
- `depth`, 4, FIFO entries; power of two, ≥2.

Ports:
- `clock`, input, 1, rising-edge clock.
- `reset`, input, 1, asynchronous, active-low.
- `Data_in`, input, `word_size_in`, FIR output, unsigned.
- `Data_in_valid`, input, 1, `Data_in` is a new filter sample this cycle.
- `Data_out`, output, `word_size_out`, head-of-FIFO sample.
- `Data_out_valid`, output, 1, FIFO non-empty.
- `Data_out_ready`, input, 1, consumer accepts `Data_out` this cycle.
- `fill_level`, output, clog2(`depth`)+1, current FIFO occupancy.
- `sat`, output, 1, one-cycle pulse: a kept sample was clipped.
- `overflow`, output, 1, one-cycle pulse: a kept sample was dropped because the FIFO was full.

## Operation
- Decimation counter: 0..`decim_factor`-1. It advances only on `Data_in_valid` and wraps to 0.
  - A sample is kept when `Data_in_valid` is high and the counter is 0.
  - The first valid sample after reset is kept.
  - `decim_factor`=1 keeps every valid sample.
- Scale stage (registered): `r = (Data_in + 2^(shift-1)) >> shift`.
  - The add is computed at `word_size_in`+1 bits, so there is no wrap.
  - If `r` > 2^`word_size_out`-1, output 2^`word_size_out`-1 and set `sat`.
  - The stage registers `sv` (valid) and `sd` (data).
- FIFO write: `sv`=1 writes `sd` at `wr_ptr`.
  - The pointers are clog2(`depth`) bits wide and wrap naturally.
  - Occupancy is a separate counter, 0..`depth`.
- FIFO read (pop): `Data_out_valid` && `Data_out_ready`; advances `rd_ptr`.
- `Data_out` = `mem[rd_ptr]` combinationally (show-ahead). Its value is don't-care when `Data_out_valid`=0.
- Full and pop in the same cycle as `sv`: the write is accepted, occupancy is unchanged, and there is no overflow.
- Full, no pop, and `sv`=1: the sample is discarded and `overflow` pulses in that cycle. Pointers and occupancy are unchanged.
- Empty: no pop occurs regardless of `Data_out_ready`, and there is no write-through bypass.
- `sat` and `overflow` can pulse in the same cycle. A saturated sample that is dropped raises both.

## Timing
- Reset (async, `reset`=0): the following are cleared within the same cycle, and outputs hold these values while reset is low:
  - decimation counter, `sv`, `sd`, pointers, occupancy → 0
  - `Data_out_valid`=0, `fill_level`=0, `sat`=0, `overflow`=0
  - `Data_out`=0, because memory is cleared too.
- Reset mid-operation discards all buffered samples and the counter phase. The first valid sample after release is kept.
- Latency: a kept sample sampled at edge N is in `sd` after N. It is written at edge N+1. `Data_out_valid` rises after edge N+1 if the FIFO was empty, so there are 2 clocks from input to output.
- `sat` is asserted after edge N, together with `sv`, for one cycle.
- `overflow` is combinational from state and `Data_out_ready` during the cycle between N and N+1.
- `fill_level` updates after each write/pop edge. With a simultaneous write and pop it is unchanged.
- Sustained throughput is one output per `decim_factor` valid inputs. No stall is ever applied upstream, because the FIR runs free.

## Test plan
- Reset then input 1000 valid once, `Data_out_ready`=1 → 2 clocks later `Data_out`=4, `Data_out_valid` high for 1 cycle, `fill_level` back to 0.
- Rounding, `decim_factor`=1: inputs 383, 384, 127, 128 → outputs 1, 2, 0, 1.
- Saturation: input 72675 (285×255 full-scale) → `Data_out`=255, `sat` pulses once. Input 65407 → 255, with no `sat` (r=255 exactly).
- Decimation: inputs 256, 512, 768, 1024, 1280 with `Data_in_valid` gaps inserted → outputs 1, 5 only. Gaps do not advance the phase.
- Overflow: `Data_out_ready`=0 with 5 kept samples → `fill_level`=4 and `overflow` pulses on the 5th. Raise `Data_out_ready` at the moment the 6th arrives → it is accepted and level stays 4. Drain order matches input order.
- Async reset asserted mid-stream with 3 entries buffered → `Data_out_valid`/`fill_level` go to 0 immediately, without a clock edge. After release, the next valid input is kept.

Source files
------------

// File: rtl/fir_decimate_buffer.sv
// Decimate the 18-bit FIR stream, round/shift/saturate kept samples to 8 bits, buffer in a show-ahead FIFO.
// Latency: 2 clocks from kept input to Data_out_valid when the FIFO is empty.
// Backpressure: none upstream; a kept sample arriving at a full FIFO with no pop is dropped and flagged.

module fir_decimate_buffer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push_vld,
    input  logic [W-1:0]               i_push_dat,
    output logic                       o_push_rdy,
    output logic                       o_pop_vld,
    output logic [W-1:0]               o_pop_dat,
    input  logic                       i_pop_rdy,
    output logic [$clog2(DEPTH):0]     o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign w_pop  = (r_count != '0) && i_pop_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push = i_push_vld && (!w_full || w_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_push_rdy = !w_full || w_pop;
    assign o_pop_vld  = (r_count != '0);
    assign o_pop_dat  = r_mem[r_rd_ptr];
    assign o_level    = r_count;
endmodule

module fir_decimate_buffer #(
    parameter int word_size_in  = 18,
    parameter int word_size_out = 8,
    parameter int decim_factor  = 4,
    parameter int shift         = 8,
    parameter int depth         = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [word_size_in-1:0]    Data_in,
    input  logic                       Data_in_valid,
    output logic [word_size_out-1:0]   Data_out,
    output logic                       Data_out_valid,
    input  logic                       Data_out_ready,
    output logic [$clog2(depth):0]     fill_level,
    output logic                       sat,
    output logic                       overflow
);
    localparam int PW = 5;
    localparam int SW = word_size_in + 1;
    localparam logic [PW-1:0] PH_LAST = PW'(decim_factor - 1);
    localparam logic [SW-1:0] RND     = SW'(1) << (shift - 1);
    localparam logic [SW-1:0] MAXO    = SW'((1 << word_size_out) - 1);

    logic [PW-1:0]            r_phase;
    logic                     r_sv;
    logic [word_size_out-1:0] r_sd;
    logic                     r_sat;

    logic                     w_keep;
    logic [SW-1:0]            w_sum;
    logic [SW-1:0]            w_scaled;
    logic                     w_clip;
    logic [word_size_out-1:0] w_sd_nxt;
    logic                     w_push_rdy;

    assign w_keep = Data_in_valid && (r_phase == '0);

    // One guard bit keeps the rounding add from wrapping near full scale.
    assign w_sum    = {1'b0, Data_in} + RND;
    assign w_scaled = w_sum >> shift;
    assign w_clip   = (w_scaled > MAXO);
    assign w_sd_nxt = w_clip ? {word_size_out{1'b1}} : w_scaled[word_size_out-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_phase <= '0;
        end else if (Data_in_valid) begin
            r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sv  <= 1'b0;
            r_sd  <= '0;
            r_sat <= 1'b0;
        end else begin
            r_sv  <= w_keep;
            r_sat <= w_keep && w_clip;
            if (w_keep) begin
                r_sd <= w_sd_nxt;
            end
        end
    end

    fir_decimate_buffer_fifo #(
        .W     (word_size_out),
        .DEPTH (depth)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push_vld (r_sv),
        .i_push_dat (r_sd),
        .o_push_rdy (w_push_rdy),
        .o_pop_vld  (Data_out_valid),
        .o_pop_dat  (Data_out),
        .i_pop_rdy  (Data_out_ready),
        .o_level    (fill_level)
    );

    assign sat      = r_sat;
    assign overflow = r_sv && !w_push_rdy;
endmodule

// File: tb/tb_fir_decimate_buffer.sv
// Randomised and directed bench for fir_decimate_buffer against a queue-based model.
module tb_fir_decimate_buffer;
    localparam int DF    = 4;
    localparam int SHIFT = 8;
    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic [17:0] Data_in;
    logic        Data_in_valid;
    logic [7:0]  Data_out;
    logic        Data_out_valid;
    logic        Data_out_ready;
    logic [2:0]  fill_level;
    logic        sat;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // model state: samples visible at the FIFO head and the one in flight
    int m_q[$];
    int m_phase = 0;
    bit m_sv = 0;
    int m_sd = 0;
    bit m_sat = 0;

    int obs[$];
    int exp_obs[$];
    int sat_cnt = 0;
    int ovf_cnt = 0;

    fir_decimate_buffer dut (
        .clock          (clock),
        .reset          (reset),
        .Data_in        (Data_in),
        .Data_in_valid  (Data_in_valid),
        .Data_out       (Data_out),
        .Data_out_valid (Data_out_valid),
        .Data_out_ready (Data_out_ready),
        .fill_level     (fill_level),
        .sat            (sat),
        .overflow       (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int scaled(input int din);
        return (din + (1 << (SHIFT - 1))) >> SHIFT;
    endfunction

    // compare process
    initial begin
        bit pop;
        bit ovf;
        bit keep;
        int r;
        forever begin
            @(negedge clock);
            #2;
            if (!reset) begin
                check("rst_data", 32'(Data_out), 0);
                check("rst_valid", 32'(Data_out_valid), 0);
                check("rst_fill", 32'(fill_level), 0);
                check("rst_sat", 32'(sat), 0);
                check("rst_ovf", 32'(overflow), 0);
                m_q.delete();
                m_phase = 0;
                m_sv = 0;
                m_sd = 0;
                m_sat = 0;
            end else begin
                pop = (m_q.size() > 0) && Data_out_ready;
                ovf = m_sv && (m_q.size() == DEPTH) && !pop;
                check("valid", 32'(Data_out_valid), 32'(m_q.size() > 0));
                check("fill", 32'(fill_level), 32'(m_q.size()));
                if (m_q.size() > 0) check("data", 32'(Data_out), 32'(m_q[0]));
                check("sat", 32'(sat), 32'(m_sv && m_sat));
                check("overflow", 32'(overflow), 32'(ovf));
                if (Data_out_valid && Data_out_ready) obs.push_back(int'(Data_out));
                if (sat) sat_cnt++;
                if (overflow) ovf_cnt++;
                if (pop) void'(m_q.pop_front());
                if (m_sv && !ovf) m_q.push_back(m_sd);
                keep = Data_in_valid && (m_phase == 0);
                r = scaled(int'(Data_in));
                m_sv = keep;
                m_sat = keep && (r > 255);
                if (keep) m_sd = (r > 255) ? 255 : r;
                if (Data_in_valid) m_phase = (m_phase + 1) % DF;
            end
        end
    end

    task automatic drive(input logic v, input logic [17:0] d, input logic rdy);
        @(negedge clock);
        Data_in_valid = v;
        Data_in = d;
        Data_out_ready = rdy;
    endtask

    task automatic send_kept(input int d, input logic rdy);
        drive(1'b1, 18'(d), rdy);
        repeat (DF - 1) drive(1'b1, 18'($urandom_range(0, 262143)), rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) drive(1'b0, 18'd0, rdy);
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b0;
        Data_in_valid = 1'b0;
        Data_out_ready = 1'b0;
        #1;
        check("reset_valid", 32'(Data_out_valid), 0);
        check("reset_fill", 32'(fill_level), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        obs.delete();
        sat_cnt = 0;
        ovf_cnt = 0;
    endtask

    task automatic check_obs(input string nm);
        check({nm, "_count"}, 32'(obs.size()), 32'(exp_obs.size()));
        for (int i = 0; i < exp_obs.size() && i < obs.size(); i++)
            check(nm, 32'(obs[i]), 32'(exp_obs[i]));
        obs.delete();
    endtask

    initial begin
        reset = 1'b0;
        Data_in = '0;
        Data_in_valid = 1'b0;
        Data_out_ready = 1'b0;

        // single sample, two-clock latency
        do_reset;
        drive(1'b1, 18'd1000, 1'b1);
        drive(1'b0, 18'd0, 1'b1);
        #1 check("lat_n1_valid", 32'(Data_out_valid), 0);
        drive(1'b0, 18'd0, 1'b1);
        #1 check("lat_n2_valid", 32'(Data_out_valid), 1);
        check("lat_n2_data", 32'(Data_out), 4);
        check("lat_n2_fill", 32'(fill_level), 1);
        drive(1'b0, 18'd0, 1'b1);
        #1 check("lat_n3_valid", 32'(Data_out_valid), 0);
        check("lat_n3_fill", 32'(fill_level), 0);
        idle(2, 1'b1);
        exp_obs = {4};
        check_obs("single");

        // rounding
        do_reset;
        send_kept(383, 1'b1);
        send_kept(384, 1'b1);
        send_kept(127, 1'b1);
        send_kept(128, 1'b1);
        idle(6, 1'b1);
        exp_obs = {1, 2, 0, 1};
        check_obs("round");

        // saturation boundary
        do_reset;
        send_kept(72675, 1'b1);
        send_kept(65407, 1'b1);
        idle(6, 1'b1);
        exp_obs = {255, 255};
        check_obs("satur");
        check("sat_pulses", 32'(sat_cnt), 1);

        // decimation with valid gaps
        do_reset;
        drive(1'b1, 18'd256, 1'b1);
        drive(1'b0, 18'd0, 1'b1);
        drive(1'b1, 18'd512, 1'b1);
        drive(1'b0, 18'd0, 1'b1);
        drive(1'b0, 18'd0, 1'b1);
        drive(1'b1, 18'd768, 1'b1);
        drive(1'b1, 18'd1024, 1'b1);
        drive(1'b0, 18'd0, 1'b1);
        drive(1'b1, 18'd1280, 1'b1);
        idle(6, 1'b1);
        exp_obs = {1, 5};
        check_obs("decim");

        // overflow, then simultaneous write and pop at full
        do_reset;
        for (int k = 1; k <= 5; k++) send_kept(k * 256, 1'b0);
        idle(3, 1'b0);
        #1 check("ovf_fill", 32'(fill_level), 4);
        check("ovf_pulses", 32'(ovf_cnt), 1);
        drive(1'b1, 18'(6 * 256), 1'b0);
        drive(1'b1, 18'd5, 1'b1);
        drive(1'b0, 18'd0, 1'b0);
        #1 check("full_pop_fill", 32'(fill_level), 4);
        check("full_pop_ovf", 32'(ovf_cnt), 1);
        idle(8, 1'b1);
        exp_obs = {1, 2, 3, 4, 6};
        check_obs("drain");

        // asynchronous reset mid-stream
        do_reset;
        send_kept(256, 1'b0);
        send_kept(512, 1'b0);
        send_kept(768, 1'b0);
        idle(3, 1'b0);
        #1 check("pre_rst_fill", 32'(fill_level), 3);
        @(posedge clock);
        #3 reset = 1'b0;
        #1 check("async_valid", 32'(Data_out_valid), 0);
        check("async_fill", 32'(fill_level), 0);
        check("async_data", 32'(Data_out), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        obs.delete();
        send_kept(2048, 1'b1);
        idle(6, 1'b1);
        exp_obs = {8};
        check_obs("post_rst");

        // randomised traffic, biased around the saturation threshold
        do_reset;
        for (int i = 0; i < 3000; i++) begin
            logic [17:0] d;
            if (i == 1500) do_reset;
            if ($urandom_range(0, 1) == 0) d = 18'($urandom_range(0, 262143));
            else d = 18'($urandom_range(60000, 80000));
            drive(logic'($urandom_range(0, 9) < 7), d, logic'($urandom_range(0, 1)));
        end
        idle(10, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
